mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage of the MPS core, placed directly upstream of the write-back stage. It accepts one instruction at a time from execute: ALU result, store data, memory-op flags and destination register. For loads and stores it runs a req/ack transaction on the data-memory port. It then presents the ALU result, loaded value, `mem_read` flag and destination register to write-back for exactly one cycle. While a transaction is outstanding it stalls execute through a valid/ready handshake.

## Interface
Parameters:
- DATA_WIDTH, default `DMEM_DATA_WIDTH` (8): data word width.
- ADDR_WIDTH, default `DMEM_ADDR_WIDTH` (8): data-memory address width.
- REG_IDX_WIDTH, default 3: destination-register index width.
- TIMEOUT, default 255: maximum number of cycles `dmem_req` may wait for `dmem_ack`.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  execute presents an instruction.
- in_ready  out  1  stage can accept an instruction.
- in_alu_z  in  DATA_WIDTH  ALU result; also the memory address, low ADDR_WIDTH bits.
- in_store_data  in  DATA_WIDTH  data to store.
- in_mem_read  in  1  instruction is a load.
- in_mem_write  in  1  instruction is a store.
- in_reg_write  in  1  instruction writes a register.
- in_d_idx  in  REG_IDX_WIDTH  destination register.
- dmem_req  out  1  memory request.
- dmem_we  out  1  request is a write.
- dmem_addr  out  ADDR_WIDTH  request address.
- dmem_wdata  out  DATA_WIDTH  write data.
- dmem_ack  in  1  one-cycle completion pulse.
- dmem_rdata  in  DATA_WIDTH  read data, valid while `dmem_ack` is high.
- wb_valid  out  1  write-back fields are valid this cycle.
- wb_alu_z  out  DATA_WIDTH  registered ALU result.
- wb_mem_value  out  DATA_WIDTH  registered load data.
- wb_mem_read  out  1  selects `wb_mem_value` in write-back.
- wb_reg_write  out  1  register write enable.
- wb_d_idx  out  REG_IDX_WIDTH  destination register.
- bus_error  out  1  sticky; set on memory timeout.

## Operation
- States: IDLE and ACCESS.
- `in_ready` = (state == IDLE).
- An instruction is accepted on a rising edge where `in_valid && in_ready`.

Accepting an instruction in IDLE:
- All input fields are latched.
- If both `in_mem_read` and `in_mem_write` are set, the store wins and the latched `mem_read` is 0.
- No memory op: the output registers load on the accept edge, `wb_valid` = 1 for the next cycle, and the state stays IDLE.
- Memory op: go to ACCESS.

In ACCESS:
- `dmem_req` = 1.
- `dmem_we`, `dmem_addr` and `dmem_wdata` come from the latched fields and stay stable until ack.
- On `dmem_ack`:
  - `wb_mem_value` captures `dmem_rdata` on a load; it holds its previous value on a store.
  - The other output fields load, `wb_valid` = 1 for the next cycle, and the state returns to IDLE.
- Timeout counter:
  - Resets to 0 on entry to ACCESS and increments each ACCESS cycle without ack.
  - On reaching TIMEOUT it forces completion: `bus_error` is set, `wb_mem_value` = 0, `wb_valid` = 1 for the next cycle, and the state returns to IDLE.
  - `bus_error` clears only on reset.
- `dmem_ack` outside ACCESS is ignored.
- `wb_valid` is a single-cycle pulse per accepted instruction and is never held for two cycles.
- Write-back has no backpressure.

## Timing
- Reset (asynchronous, `rst_n` low) forces: state IDLE, `in_ready` 1, `dmem_req` 0, `dmem_we` 0, `dmem_addr` 0, `dmem_wdata` 0, `wb_valid` 0, all `wb_*` data 0, `bus_error` 0, counter 0.
- Reset asserted mid-ACCESS drops `dmem_req` immediately; a late ack after reset is ignored.
- Non-memory latency: accept at edge N, `wb_valid` high in cycle N+1. Throughput is 1 per cycle.
- Memory latency:
  - Accept at edge N; `dmem_req` is high from cycle N+1.
  - Ack sampled at edge M ≥ N+1; `wb_valid` is high in cycle M+1.
- `in_ready` rises in cycle M+1, so the next instruction can be accepted at edge M+1, overlapping the `wb_valid` cycle.
- `dmem_req` falls in cycle M+1. No new request starts before cycle M+2.

## Structure
- `DMEM_DATA_WIDTH` and `DMEM_ADDR_WIDTH` come from `config.inc.v`.
- The state encoding (IDLE=0, ACCESS=1) is defined in `config.inc.v` as `MEMSTG_*` macros.
- The timeout counter is one natural sub-module, `mem_timeout_counter`, with ports clear, enable, count and expired. The counter is $clog2(TIMEOUT+1) bits wide.
- The FSM, the latches and the output registers stay in `mem_stage`.

## Test plan
- ALU-only: accept in_alu_z=0x2A, d_idx=3, reg_write=1 -> next cycle wb_valid=1, wb_alu_z=0x2A, wb_mem_read=0, wb_d_idx=3; no dmem_req.
- Load, 3-cycle ack: in_alu_z=0x10, mem_read=1; memory returns 0xC3 on the third req cycle -> dmem_addr=0x10 stable, dmem_we=0; wb_valid one cycle after ack with wb_mem_value=0xC3, wb_mem_read=1; in_ready low throughout ACCESS.
- Store, immediate ack, then back-to-back ALU op: store 0x55 to 0x20 -> dmem_we=1, dmem_wdata=0x55; the next instruction is accepted in the wb_valid cycle; two wb_valid pulses on consecutive cycles.
- Read and write both set: store performed, wb_mem_read=0.
- Timeout with TIMEOUT=4, no ack -> after 4 req cycles, bus_error=1 and stays set; wb_valid pulses with wb_mem_value=0; a later stray ack is ignored.
- Reset mid-ACCESS -> dmem_req drops asynchronously; wb_valid=0, in_ready=1; the next instruction proceeds normally.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared widths and state encoding for the memory-access pipeline stage.
package mem_stage_pkg;

  localparam int DMEM_DATA_WIDTH = 8;
  localparam int DMEM_ADDR_WIDTH = 8;

  typedef enum logic {
    MEMSTG_IDLE   = 1'b0,
    MEMSTG_ACCESS = 1'b1
  } memstg_state_e;

  function automatic logic is_mem_op(input logic mem_read, input logic mem_write);
    return mem_read | mem_write;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack port; the stage is master, the memory is slave.
interface mem_stage_if
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH
);

  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ack;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);

endinterface

// File: rtl/mem_timeout_counter.sv
// Up-counter of unacknowledged request cycles; expired flags the cycle whose
// increment would reach TIMEOUT.
module mem_timeout_counter #(
  parameter int TIMEOUT = 255,
  localparam int CNT_W  = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + CNT_W'(1);
  end

  assign expired = enable && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: latches one instruction from execute, runs a dmem
// req/ack transaction for loads/stores, then pulses results to write-back.
//
// state   | meaning
// IDLE    | ready for an instruction; ALU-only ops complete from here
// ACCESS  | dmem_req held high until ack or timeout
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH    = DMEM_DATA_WIDTH,
  parameter int ADDR_WIDTH    = DMEM_ADDR_WIDTH,
  parameter int REG_IDX_WIDTH = 3,
  parameter int TIMEOUT       = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_alu_z,
  input  logic [DATA_WIDTH-1:0]    in_store_data,
  input  logic                     in_mem_read,
  input  logic                     in_mem_write,
  input  logic                     in_reg_write,
  input  logic [REG_IDX_WIDTH-1:0] in_d_idx,
  mem_stage_if.master              dmem,
  output logic                     wb_valid,
  output logic [DATA_WIDTH-1:0]    wb_alu_z,
  output logic [DATA_WIDTH-1:0]    wb_mem_value,
  output logic                     wb_mem_read,
  output logic                     wb_reg_write,
  output logic [REG_IDX_WIDTH-1:0] wb_d_idx,
  output logic                     bus_error
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  memstg_state_e state, state_nxt;

  logic                     accept, mem_op, done_ack, done_to;
  logic                     to_enable, to_expired;
  logic [CNT_W-1:0]         unused_to_count;
  logic [DATA_WIDTH-1:0]    lat_alu_z;
  logic [DATA_WIDTH-1:0]    lat_wdata;
  logic [ADDR_WIDTH-1:0]    lat_addr;
  logic                     lat_we, lat_mem_read, lat_reg_write;
  logic [REG_IDX_WIDTH-1:0] lat_d_idx;

  assign in_ready  = (state == MEMSTG_IDLE);
  assign accept    = in_valid && in_ready;
  assign mem_op    = is_mem_op(in_mem_read, in_mem_write);
  assign to_enable = (state == MEMSTG_ACCESS) && !dmem.ack;

  mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept && mem_op),
    .enable  (to_enable),
    .count   (unused_to_count),
    .expired (to_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MEMSTG_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done_ack  = 1'b0;
    done_to   = 1'b0;
    case (state)
      MEMSTG_IDLE: begin
        if (accept && mem_op) state_nxt = MEMSTG_ACCESS;
      end
      MEMSTG_ACCESS: begin
        // A same-cycle ack takes priority over the timeout.
        done_ack = dmem.ack;
        done_to  = to_expired;
        if (done_ack || done_to) state_nxt = MEMSTG_IDLE;
      end
      default: state_nxt = MEMSTG_IDLE;
    endcase
  end

  // Store wins when both memory flags are set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_alu_z     <= '0;
      lat_wdata     <= '0;
      lat_addr      <= '0;
      lat_we        <= 1'b0;
      lat_mem_read  <= 1'b0;
      lat_reg_write <= 1'b0;
      lat_d_idx     <= '0;
    end else if (accept) begin
      lat_alu_z     <= in_alu_z;
      lat_wdata     <= in_store_data;
      lat_addr      <= in_alu_z[ADDR_WIDTH-1:0];
      lat_we        <= in_mem_write;
      lat_mem_read  <= in_mem_read && !in_mem_write;
      lat_reg_write <= in_reg_write;
      lat_d_idx     <= in_d_idx;
    end
  end

  assign dmem.req   = (state == MEMSTG_ACCESS);
  assign dmem.we    = lat_we;
  assign dmem.addr  = lat_addr;
  assign dmem.wdata = lat_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid     <= 1'b0;
      wb_alu_z     <= '0;
      wb_mem_value <= '0;
      wb_mem_read  <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_d_idx     <= '0;
      bus_error    <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      if (accept && !mem_op) begin
        wb_valid     <= 1'b1;
        wb_alu_z     <= in_alu_z;
        wb_mem_read  <= 1'b0;
        wb_reg_write <= in_reg_write;
        wb_d_idx     <= in_d_idx;
      end else if (done_ack || done_to) begin
        wb_valid     <= 1'b1;
        wb_alu_z     <= lat_alu_z;
        wb_mem_read  <= lat_mem_read;
        wb_reg_write <= lat_reg_write;
        wb_d_idx     <= lat_d_idx;
        if (done_to) begin
          wb_mem_value <= '0;
          bus_error    <= 1'b1;
        end else if (lat_mem_read) begin
          wb_mem_value <= dmem.rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with TIMEOUT=4; inputs change and outputs are
// sampled 1 ns after each rising edge.
module tb_mem_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [7:0] in_alu_z, in_store_data;
  logic       in_mem_read, in_mem_write, in_reg_write;
  logic [2:0] in_d_idx;
  logic       wb_valid, wb_mem_read, wb_reg_write, bus_error;
  logic [7:0] wb_alu_z, wb_mem_value;
  logic [2:0] wb_d_idx;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dmem_bus ();

  mem_stage #(
    .DATA_WIDTH(8), .ADDR_WIDTH(8), .REG_IDX_WIDTH(3), .TIMEOUT(4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_alu_z      (in_alu_z),
    .in_store_data (in_store_data),
    .in_mem_read   (in_mem_read),
    .in_mem_write  (in_mem_write),
    .in_reg_write  (in_reg_write),
    .in_d_idx      (in_d_idx),
    .dmem          (dmem_bus),
    .wb_valid      (wb_valid),
    .wb_alu_z      (wb_alu_z),
    .wb_mem_value  (wb_mem_value),
    .wb_mem_read   (wb_mem_read),
    .wb_reg_write  (wb_reg_write),
    .wb_d_idx      (wb_d_idx),
    .bus_error     (bus_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] z, input logic [7:0] sd,
                       input logic rd, input logic wr, input logic rw, input logic [2:0] d);
    in_valid      = v;
    in_alu_z      = z;
    in_store_data = sd;
    in_mem_read   = rd;
    in_mem_write  = wr;
    in_reg_write  = rw;
    in_d_idx      = d;
  endtask

  initial begin
    rst_n = 1'b0;
    dmem_bus.ack   = 1'b0;
    dmem_bus.rdata = 8'h00;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_req", dmem_bus.req, 0);
    check("rst_we", dmem_bus.we, 0);
    check("rst_addr", dmem_bus.addr, 0);
    check("rst_wdata", dmem_bus.wdata, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_alu_z", wb_alu_z, 0);
    check("rst_wb_mem_value", wb_mem_value, 0);
    check("rst_bus_error", bus_error, 0);
    step();
    rst_n = 1'b1;
    step();

    // ALU-only
    drive(1'b1, 8'h2A, 8'h00, 1'b0, 1'b0, 1'b1, 3'd3);
    step();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
    check("alu_wb_valid", wb_valid, 1);
    check("alu_wb_alu_z", wb_alu_z, 8'h2A);
    check("alu_wb_mem_read", wb_mem_read, 0);
    check("alu_wb_reg_write", wb_reg_write, 1);
    check("alu_wb_d_idx", wb_d_idx, 3);
    check("alu_no_req", dmem_bus.req, 0);
    check("alu_in_ready", in_ready, 1);
    step();
    check("alu_pulse_end", wb_valid, 0);

    // Load, ack on third request cycle
    drive(1'b1, 8'h10, 8'h99, 1'b1, 1'b0, 1'b1, 3'd5);
    step();
    drive(1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
    check("ld_req_c1", dmem_bus.req, 1);
    check("ld_we", dmem_bus.we, 0);
    check("ld_addr_c1", dmem_bus.addr, 8'h10);
    check("ld_in_ready_c1", in_ready, 0);
    check("ld_wb_valid_c1", wb_valid, 0);
    step();
    check("ld_req_c2", dmem_bus.req, 1);
    check("ld_addr_c2", dmem_bus.addr, 8'h10);
    check("ld_in_ready_c2", in_ready, 0);
    step();
    check("ld_req_c3", dmem_bus.req, 1);
    check("ld_addr_c3", dmem_bus.addr, 8'h10);
    dmem_bus.ack   = 1'b1;
    dmem_bus.rdata = 8'hC3;
    step();
    dmem_bus.ack   = 1'b0;
    dmem_bus.rdata = 8'h00;
    check("ld_wb_valid", wb_valid, 1);
    check("ld_wb_mem_value", wb_mem_value, 8'hC3);
    check("ld_wb_mem_read", wb_mem_read, 1);
    check("ld_wb_alu_z", wb_alu_z, 8'h10);
    check("ld_wb_d_idx", wb_d_idx, 5);
    check("ld_req_drop", dmem_bus.req, 0);
    check("ld_in_ready_back", in_ready, 1);
    step();
    check("ld_pulse_end", wb_valid, 0);

    // Store, immediate ack, back-to-back ALU op in the wb_valid cycle
    drive(1'b1, 8'h20, 8'h55, 1'b0, 1'b1, 1'b0, 3'd0);
    step();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
    check("st_req", dmem_bus.req, 1);
    check("st_we", dmem_bus.we, 1);
    check("st_addr", dmem_bus.addr, 8'h20);
    check("st_wdata", dmem_bus.wdata, 8'h55);
    dmem_bus.ack = 1'b1;
    step();
    dmem_bus.ack = 1'b0;
    check("st_wb_valid", wb_valid, 1);
    check("st_wb_mem_read", wb_mem_read, 0);
    check("st_mem_value_hold", wb_mem_value, 8'hC3);
    check("st_in_ready", in_ready, 1);
    drive(1'b1, 8'h77, 8'h00, 1'b0, 1'b0, 1'b1, 3'd1);
    step();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
    check("b2b_wb_valid", wb_valid, 1);
    check("b2b_wb_alu_z", wb_alu_z, 8'h77);
    check("b2b_wb_d_idx", wb_d_idx, 1);
    check("b2b_no_req", dmem_bus.req, 0);
    step();
    check("b2b_pulse_end", wb_valid, 0);

    // Read and write both set: store wins
    drive(1'b1, 8'h30, 8'hAA, 1'b1, 1'b1, 1'b0, 3'd2);
    step();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
    check("rw_we", dmem_bus.we, 1);
    check("rw_wdata", dmem_bus.wdata, 8'hAA);
    dmem_bus.ack   = 1'b1;
    dmem_bus.rdata = 8'h11;
    step();
    dmem_bus.ack   = 1'b0;
    dmem_bus.rdata = 8'h00;
    check("rw_wb_valid", wb_valid, 1);
    check("rw_wb_mem_read", wb_mem_read, 0);
    check("rw_mem_value_hold", wb_mem_value, 8'hC3);
    step();

    // Timeout after four request cycles
    drive(1'b1, 8'h40, 8'h00, 1'b1, 1'b0, 1'b1, 3'd6);
    step();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
    check("to_req_c1", dmem_bus.req, 1);
    step();
    check("to_req_c2", dmem_bus.req, 1);
    step();
    check("to_req_c3", dmem_bus.req, 1);
    step();
    check("to_req_c4", dmem_bus.req, 1);
    check("to_no_err_c4", bus_error, 0);
    check("to_no_valid_c4", wb_valid, 0);
    step();
    check("to_req_drop", dmem_bus.req, 0);
    check("to_bus_error", bus_error, 1);
    check("to_wb_valid", wb_valid, 1);
    check("to_wb_mem_value", wb_mem_value, 0);
    check("to_wb_alu_z", wb_alu_z, 8'h40);
    check("to_in_ready", in_ready, 1);
    dmem_bus.ack   = 1'b1;
    dmem_bus.rdata = 8'hEE;
    step();
    dmem_bus.ack   = 1'b0;
    dmem_bus.rdata = 8'h00;
    check("stray_wb_valid", wb_valid, 0);
    check("stray_mem_value", wb_mem_value, 0);
    check("stray_req", dmem_bus.req, 0);
    check("sticky_bus_error", bus_error, 1);
    step();

    // Reset mid-ACCESS
    drive(1'b1, 8'h50, 8'h00, 1'b1, 1'b0, 1'b1, 3'd4);
    step();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
    check("mr_req_before", dmem_bus.req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_req_async", dmem_bus.req, 0);
    check("mr_in_ready", in_ready, 1);
    check("mr_wb_valid", wb_valid, 0);
    check("mr_bus_error", bus_error, 0);
    dmem_bus.ack   = 1'b1;
    dmem_bus.rdata = 8'h5A;
    step();
    rst_n = 1'b1;
    step();
    dmem_bus.ack   = 1'b0;
    dmem_bus.rdata = 8'h00;
    check("late_ack_wb_valid", wb_valid, 0);
    check("late_ack_req", dmem_bus.req, 0);
    check("late_ack_mem_value", wb_mem_value, 0);
    drive(1'b1, 8'h66, 8'h00, 1'b0, 1'b0, 1'b1, 3'd2);
    step();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
    check("post_rst_wb_valid", wb_valid, 1);
    check("post_rst_wb_alu_z", wb_alu_z, 8'h66);
    check("post_rst_wb_d_idx", wb_d_idx, 2);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
